// File: rtl/cla_mp_seq.sv
// Multi-precision add/subtract sequencer: one 32-bit carry-lookahead adder reused
// once per limb, LSB limb first, with the inter-limb carry held in a register.

module cla_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_p,
    output logic       o_g
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum = w_p ^ w_c;
    // Group propagate/generate do not depend on i_cin, so the next level has no loop.
    assign o_p   = &w_p;
    assign o_g   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

module cla_32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [7:0] w_pg;
    logic [7:0] w_gg;
    logic [8:0] w_gc;

    for (genvar k = 0; k < 8; k++) begin : g_grp
        cla_4 u_grp (
            .i_a   (i_a[k*4 +: 4]),
            .i_b   (i_b[k*4 +: 4]),
            .i_cin (w_gc[k]),
            .o_sum (o_sum[k*4 +: 4]),
            .o_p   (w_pg[k]),
            .o_g   (w_gg[k])
        );
    end

    always_comb begin
        w_gc    = '0;
        w_gc[0] = i_cin;
        for (int k = 0; k < 8; k++) begin
            w_gc[k+1] = w_gg[k] | (w_pg[k] & w_gc[k]);
        end
    end

    assign o_cout = w_gc[8];
endmodule

module cla_mp_seq #(
    parameter int WORDS = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_sub,
    input  logic [WORDS*32-1:0] i_a,
    input  logic [WORDS*32-1:0] i_b,
    output logic                o_busy,
    output logic                o_done,
    output logic [WORDS*32-1:0] o_result,
    output logic                o_cout,
    output logic                o_ovf
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WORDS-1:0][31:0] r_a;
    logic [WORDS-1:0][31:0] r_b;
    logic [WORDS-1:0][31:0] r_res;
    logic [IW-1:0]          r_idx;
    logic                   r_carry;
    logic                   r_busy;
    logic                   r_cout;
    logic                   r_ovf;
    logic [31:0]            w_sum;
    logic                   w_cout;
    logic                   w_last;
    logic                   w_accept;

    cla_32 u_cla (
        .i_a    (r_a[r_idx]),
        .i_b    (r_b[r_idx]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = (r_idx == IW'(WORDS - 1));
        case (r_state)
            S_IDLE: if (i_start) begin
                w_state_nxt = S_RUN;
                w_accept    = 1'b1;
            end
            S_RUN:  if (w_last) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b with the limb-0 carry-in set, so b is stored inverted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_accept) begin
                r_a     <= i_a;
                r_b     <= i_sub ? ~i_b : i_b;
                r_carry <= i_sub;
                r_idx   <= '0;
                r_res   <= '0;
                r_cout  <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_res[r_idx] <= w_sum;
                r_carry      <= w_cout;
                // idx parks at 0 after the top limb so it never indexes past the array.
                r_idx        <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) begin
                    r_cout <= w_cout;
                    r_ovf  <= (r_a[WORDS-1][31] == r_b[WORDS-1][31])
                           && (w_sum[31] != r_a[WORDS-1][31]);
                end
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = (r_state == S_DONE);
    assign o_result = r_res;
    assign o_cout   = r_cout;
    assign o_ovf    = r_ovf;
endmodule
